xgriscv_pc_unit: RTL and testbench
==================================

Name: xgriscv_pc_unit

Overview:
- Parametrised program-counter unit that replaces the combinational next-PC logic.
- Owns the PC register and the fetch-valid handshake.
- Resolves branch and jump redirects from execute using compare flags rather than the raw ALU result.
- Applies stall and flush, and halts on misaligned targets.
- Sits between the instruction-memory address port and the execute stage of the xgriscv core.

Parameters:
- XLEN, 32: datapath and PC width.
- RESET_PC, 32'h0000_0000: PC value loaded on reset.
- ILEN_BYTES, 4: sequential increment; must be 4, or 2 when a compressed-capable core is built.
- CNT_W, 32: width of the performance counters (only under the optional feature).

Ports:
- clk  in  1  core clock, rising edge.
- rstn  in  1  synchronous active-low reset.
- stall  in  1  hold PC and fetch_valid (decode not ready).
- ex_valid  in  1  execute stage holds a real instruction.
- ex_branch  in  1  execute instruction is a conditional branch.
- ex_jal  in  1  execute instruction is jal.
- ex_jalr  in  1  execute instruction is jalr.
- ex_funct3  in  3  branch condition code.
- ex_eq  in  1  rs1 == rs2.
- ex_lt  in  1  signed rs1 < rs2.
- ex_ltu  in  1  unsigned rs1 < rs2.
- ex_pc  in  XLEN  PC of the execute instruction.
- ex_imm  in  XLEN  sign-extended immediate.
- ex_rs1  in  XLEN  rs1 value (forwarded).
- pc  out  XLEN  current fetch address.
- pc_plus  out  XLEN  pc + ILEN_BYTES (link value for the fetch stage).
- fetch_valid  out  1  pc is a valid fetch request.
- flush  out  1  one-cycle pulse; kill IF/ID contents.
- redirect_pc  out  XLEN  target of the current redirect.
- fault  out  1  misaligned-target trap, sticky.
- perf_branches  out  CNT_W  (optional feature only).
- perf_redirects  out  CNT_W  (optional feature only).

Behaviour:
- Reset:
  - Clock and reset: one clock, clk. Reset rstn is synchronous and active-low.
  - Values while rstn=0 at a clock edge: pc=RESET_PC, fetch_valid=0, flush=0, fault=0, redirect_pc=0, counters=0.
  - State after reset: BOOT.
- States: BOOT, RUN, HALT.
  - BOOT: fetch_valid=0 for exactly one cycle, then RUN. pc stays RESET_PC, so the first fetch is at RESET_PC.
  - RUN: fetch_valid=1.
  - HALT: fetch_valid=0, pc frozen, fault=1. Only a reset exits HALT.
- Condition taken (ex_funct3): 000 eq; 001 !eq; 100 lt; 101 !lt; 110 ltu; 111 !ltu; 010/011 never taken.
- redirect = ex_valid & ((ex_branch & taken) | ex_jal | ex_jalr).
- Target computation, XLEN-bit, wraps modulo 2^XLEN with no overflow detection:
  - Branch or jal: ex_pc + ex_imm.
  - jalr: (ex_rs1 + ex_imm) with bit0 cleared.
- Misalignment: target[1:0] != 0 when ILEN_BYTES=4, or target[0] when ILEN_BYTES=2.
  - A misaligned redirect goes to HALT next cycle, and fault=1.
  - The PC does not update and flush is not asserted.
- Next-PC priority in RUN:
  1. Valid aligned redirect: pc <= target, flush=1 combinationally in the same cycle, redirect_pc=target. Applies even when stall=1, because redirect beats stall.
  2. stall=1: pc holds.
  3. Otherwise: pc <= pc + ILEN_BYTES.
- Zero-cycle latency from ex_* to flush and redirect_pc; one-cycle latency to pc.
- ex_valid=0: all ex_* inputs are ignored. Multiple ex_branch/ex_jal/ex_jalr asserted together: jalr beats jal, which beats branch.
- Signals held outside RUN:
  - flush=0 in BOOT and HALT.
  - pc_plus = pc + ILEN_BYTES always.
  - redirect_pc is registered as the last target and holds otherwise.
- Reset mid-redirect: reset wins; no flush is issued.
- PC wrap: pc = 2^XLEN - 4 increments to 0.

Optional Feature:
- Macro: XGRISCV_PC_PERF_EN.
- With the macro defined:
  - perf_branches increments on each cycle where ex_valid & ex_branch in RUN.
  - perf_redirects increments on each non-faulting redirect.
  - Both saturate at all-ones and clear on reset.
- Without the macro: both ports are driven constant 0, and no counter flops are synthesised.

Test Plan:
- Reset release, RESET_PC=32'h80 -> fetch_valid=0 for 1 cycle; then pc sequence 0x80, 0x84, 0x88 with fetch_valid=1.
- beq with ex_eq=1, ex_pc=0x100, ex_imm=-8 -> flush pulse 1 cycle, redirect_pc=0xF8, pc=0xF8 next cycle. bge with ex_lt=1 -> no redirect, pc+4.
- jalr with ex_rs1=0x203, ex_imm=0 -> target 0x202 misaligned -> fault=1, HALT, fetch_valid=0, pc frozen; stays until rstn=0.
- stall=1 for 3 cycles -> pc holds. A jal (ex_pc=0x40, imm=0x20) during the stall -> pc=0x60 next cycle regardless of stall.
- pc=0xFFFF_FFFC, no events -> next pc=0x0000_0000. funct3=010 branch with all flags 1 -> not taken.
- With XGRISCV_PC_PERF_EN: 5 branches, 2 taken, plus 1 jal -> perf_branches=5, perf_redirects=3. Without the macro, both read 0.

Source files
------------

// File: rtl/xgriscv_pc_unit.sv
// Program-counter unit: owns the PC, the fetch-valid handshake and branch/jump redirects.
// Optional perf counters are built only when XGRISCV_PC_PERF_EN is defined.
module xgriscv_pc_unit #(
  parameter int              XLEN       = 32,
  parameter logic [XLEN-1:0] RESET_PC   = '0,
  parameter int              ILEN_BYTES = 4,
  parameter int              CNT_W      = 32
) (
  input  logic            clk,
  input  logic            rstn,
  input  logic            stall,
  input  logic            ex_valid,
  input  logic            ex_branch,
  input  logic            ex_jal,
  input  logic            ex_jalr,
  input  logic [2:0]      ex_funct3,
  input  logic            ex_eq,
  input  logic            ex_lt,
  input  logic            ex_ltu,
  input  logic [XLEN-1:0] ex_pc,
  input  logic [XLEN-1:0] ex_imm,
  input  logic [XLEN-1:0] ex_rs1,
  output logic [XLEN-1:0] pc,
  output logic [XLEN-1:0] pc_plus,
  output logic            fetch_valid,
  output logic            flush,
  output logic [XLEN-1:0] redirect_pc,
  output logic            fault,
  output logic [CNT_W-1:0] perf_branches,
  output logic [CNT_W-1:0] perf_redirects
);

  typedef enum logic [1:0] {BOOT, RUN, HALT} state_t;

  localparam logic [XLEN-1:0] INC = XLEN'(ILEN_BYTES);

  state_t          state_q, state_d;
  logic [XLEN-1:0] pc_q, pc_d;
  logic [XLEN-1:0] redirect_q;
  logic            taken;
  logic            redirect;
  logic            misaligned;
  logic [XLEN-1:0] jalr_sum;
  logic [XLEN-1:0] target;

  always_comb begin
    taken = 1'b0;
    case (ex_funct3)
      3'b000:  taken = ex_eq;
      3'b001:  taken = !ex_eq;
      3'b100:  taken = ex_lt;
      3'b101:  taken = !ex_lt;
      3'b110:  taken = ex_ltu;
      3'b111:  taken = !ex_ltu;
      default: taken = 1'b0;
    endcase
  end

  assign redirect = ex_valid & ((ex_branch & taken) | ex_jal | ex_jalr);
  assign jalr_sum = ex_rs1 + ex_imm;

  // jalr outranks jal/branch when decode flags overlap
  always_comb begin
    target = ex_pc + ex_imm;
    if (ex_jalr) target = {jalr_sum[XLEN-1:1], 1'b0};
  end

  always_comb begin
    misaligned = |target[1:0];
    if (ILEN_BYTES == 2) misaligned = target[0];
  end

  // Redirect wins over stall; reset suppresses any pending flush.
  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    flush   = 1'b0;
    case (state_q)
      BOOT: state_d = RUN;
      RUN: begin
        if (redirect && !misaligned) begin
          pc_d  = target;
          flush = rstn;
        end else if (redirect) begin
          state_d = HALT;
        end else if (!stall) begin
          pc_d = pc_q + INC;
        end
      end
      HALT:    state_d = HALT;
      default: state_d = BOOT;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      state_q    <= BOOT;
      pc_q       <= RESET_PC;
      redirect_q <= '0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      if (flush) redirect_q <= target;
    end
  end

  assign pc          = pc_q;
  assign pc_plus     = pc_q + INC;
  assign fetch_valid = (state_q == RUN);
  assign fault       = (state_q == HALT);
  assign redirect_pc = flush ? target : redirect_q;

`ifdef XGRISCV_PC_PERF_EN
  logic [CNT_W-1:0] br_cnt, rd_cnt;

  // Both counters saturate at all-ones
  always_ff @(posedge clk) begin
    if (!rstn) begin
      br_cnt <= '0;
      rd_cnt <= '0;
    end else begin
      if ((state_q == RUN) && ex_valid && ex_branch && !(&br_cnt))
        br_cnt <= br_cnt + CNT_W'(1);
      if (flush && !(&rd_cnt))
        rd_cnt <= rd_cnt + CNT_W'(1);
    end
  end

  assign perf_branches  = br_cnt;
  assign perf_redirects = rd_cnt;
`else
  assign perf_branches  = '0;
  assign perf_redirects = '0;
`endif

endmodule

// File: tb/tb_xgriscv_pc_unit.sv
// Directed-vector bench for xgriscv_pc_unit with a queue scoreboard and a negedge monitor.
module tb_xgriscv_pc_unit;

  logic        clk = 1'b0;
  logic        rstn, stall, ex_valid, ex_branch, ex_jal, ex_jalr;
  logic [2:0]  ex_funct3;
  logic        ex_eq, ex_lt, ex_ltu;
  logic [31:0] ex_pc, ex_imm, ex_rs1;
  logic [31:0] pc, pc_plus, redirect_pc;
  logic        fetch_valid, flush, fault;
  logic [31:0] perf_branches, perf_redirects;

  typedef struct {
    logic [31:0] pc;
    logic        fv;
    logic        fl;
    logic [31:0] rpc;
    logic        flt;
    logic [31:0] pb;
    logic [31:0] pr;
  } exp_t;

  exp_t        sb[$];
  int          n_cmp = 0;
  int          n_bad = 0;
  logic [31:0] m_br = 0;
  logic [31:0] m_rd = 0;

  always #5 clk = ~clk;

  xgriscv_pc_unit #(
    .XLEN(32), .RESET_PC(32'h80), .ILEN_BYTES(4), .CNT_W(32)
  ) dut (
    .clk(clk), .rstn(rstn), .stall(stall),
    .ex_valid(ex_valid), .ex_branch(ex_branch), .ex_jal(ex_jal), .ex_jalr(ex_jalr),
    .ex_funct3(ex_funct3), .ex_eq(ex_eq), .ex_lt(ex_lt), .ex_ltu(ex_ltu),
    .ex_pc(ex_pc), .ex_imm(ex_imm), .ex_rs1(ex_rs1),
    .pc(pc), .pc_plus(pc_plus), .fetch_valid(fetch_valid), .flush(flush),
    .redirect_pc(redirect_pc), .fault(fault),
    .perf_branches(perf_branches), .perf_redirects(perf_redirects)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Monitor: one expectation per cycle, sampled mid-cycle
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (sb.size() > 0) begin
        e = sb.pop_front();
        chk("pc", pc, e.pc);
        chk("pc_plus", pc_plus, e.pc + 32'd4);
        chk("fetch_valid", {31'd0, fetch_valid}, {31'd0, e.fv});
        chk("flush", {31'd0, flush}, {31'd0, e.fl});
        chk("redirect_pc", redirect_pc, e.rpc);
        chk("fault", {31'd0, fault}, {31'd0, e.flt});
        chk("perf_branches", perf_branches, e.pb);
        chk("perf_redirects", perf_redirects, e.pr);
      end
    end
  end

  task automatic drive(input logic r, input logic s, input logic v, input logic br,
                       input logic j, input logic jr, input logic [2:0] f3,
                       input logic e, input logic l, input logic lu,
                       input logic [31:0] p, input logic [31:0] im, input logic [31:0] rs);
    rstn = r; stall = s; ex_valid = v; ex_branch = br; ex_jal = j; ex_jalr = jr;
    ex_funct3 = f3; ex_eq = e; ex_lt = l; ex_ltu = lu;
    ex_pc = p; ex_imm = im; ex_rs1 = rs;
  endtask

  task automatic idle(input logic r, input logic s);
    drive(r, s, 1'b0, 1'b0, 1'b0, 1'b0, 3'b000, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 32'h0);
  endtask

  // Push this cycle's expected outputs, then advance one clock.
  task automatic expect_cyc(input logic [31:0] epc, input logic efv, input logic efl,
                            input logic [31:0] erpc, input logic eflt);
    exp_t e;
    e.pc = epc; e.fv = efv; e.fl = efl; e.rpc = erpc; e.flt = eflt;
`ifdef XGRISCV_PC_PERF_EN
    e.pb = m_br; e.pr = m_rd;
`else
    e.pb = 32'd0; e.pr = 32'd0;
`endif
    sb.push_back(e);
    if (!rstn) begin
      m_br = 0;
      m_rd = 0;
    end else begin
      if (efv && ex_valid && ex_branch) m_br = m_br + 1;
      if (efl) m_rd = m_rd + 1;
    end
    @(posedge clk);
    #1;
  endtask

  initial begin
    idle(1'b0, 1'b0);
    repeat (2) @(posedge clk);
    #1;
    // reset hold and BOOT, then sequential fetch from 0x80
    idle(0, 0);                                   expect_cyc(32'h80, 0, 0, 32'h0, 0);
    idle(1, 0);                                   expect_cyc(32'h80, 0, 0, 32'h0, 0);
    idle(1, 0);                                   expect_cyc(32'h80, 1, 0, 32'h0, 0);
    idle(1, 0);                                   expect_cyc(32'h84, 1, 0, 32'h0, 0);
    // beq taken, pc 0x100 + (-8)
    drive(1, 0, 1, 1, 0, 0, 3'b000, 1, 0, 0, 32'h100, 32'hFFFF_FFF8, 32'h0);
    expect_cyc(32'h88, 1, 1, 32'hF8, 0);
    // bge with lt=1: not taken
    drive(1, 0, 1, 1, 0, 0, 3'b101, 0, 1, 0, 32'h100, 32'h4, 32'h0);
    expect_cyc(32'hF8, 1, 0, 32'hF8, 0);
    // funct3=010 with all flags set: never taken
    drive(1, 0, 1, 1, 0, 0, 3'b010, 1, 1, 1, 32'h100, 32'h4, 32'h0);
    expect_cyc(32'hFC, 1, 0, 32'hF8, 0);
    // bne taken
    drive(1, 0, 1, 1, 0, 0, 3'b001, 0, 0, 0, 32'h200, 32'h10, 32'h0);
    expect_cyc(32'h100, 1, 1, 32'h210, 0);
    // bltu with ltu=0: not taken
    drive(1, 0, 1, 1, 0, 0, 3'b110, 0, 0, 0, 32'h300, 32'h4, 32'h0);
    expect_cyc(32'h210, 1, 0, 32'h210, 0);
    // stall holds, jal during stall still redirects
    idle(1, 1);                                   expect_cyc(32'h214, 1, 0, 32'h210, 0);
    idle(1, 1);                                   expect_cyc(32'h214, 1, 0, 32'h210, 0);
    drive(1, 1, 1, 0, 1, 0, 3'b000, 0, 0, 0, 32'h40, 32'h20, 32'h0);
    expect_cyc(32'h214, 1, 1, 32'h60, 0);
    // jal with ex_valid=0 is ignored
    drive(1, 0, 0, 0, 1, 0, 3'b000, 0, 0, 0, 32'h0, 32'h4, 32'h0);
    expect_cyc(32'h60, 1, 0, 32'h60, 0);
    // jalr + jal together: jalr target (0x1001+0x10)&~1
    drive(1, 0, 1, 0, 1, 1, 3'b000, 0, 0, 0, 32'h500, 32'h10, 32'h1001);
    expect_cyc(32'h64, 1, 1, 32'h1010, 0);
    // jal to 0xFFFF_FFFC, then wrap to 0
    drive(1, 0, 1, 0, 1, 0, 3'b000, 0, 0, 0, 32'hFFFF_FF00, 32'hFC, 32'h0);
    expect_cyc(32'h1010, 1, 1, 32'hFFFF_FFFC, 0);
    idle(1, 0);                                   expect_cyc(32'hFFFF_FFFC, 1, 0, 32'hFFFF_FFFC, 0);
    // misaligned jalr target 0x202 -> HALT
    drive(1, 0, 1, 0, 0, 1, 3'b000, 0, 0, 0, 32'h0, 32'h0, 32'h203);
    expect_cyc(32'h0, 1, 0, 32'hFFFF_FFFC, 0);
    idle(1, 0);                                   expect_cyc(32'h0, 0, 0, 32'hFFFF_FFFC, 1);
    drive(1, 0, 1, 0, 1, 0, 3'b000, 0, 0, 0, 32'h0, 32'h8, 32'h0);
    expect_cyc(32'h0, 0, 0, 32'hFFFF_FFFC, 1);
    idle(1, 1);                                   expect_cyc(32'h0, 0, 0, 32'hFFFF_FFFC, 1);
    // only reset leaves HALT
    idle(0, 0);                                   expect_cyc(32'h0, 0, 0, 32'hFFFF_FFFC, 1);
    idle(1, 0);                                   expect_cyc(32'h80, 0, 0, 32'h0, 0);
    idle(1, 0);                                   expect_cyc(32'h80, 1, 0, 32'h0, 0);
    // reset concurrent with a jal: no flush
    drive(0, 0, 1, 0, 1, 0, 3'b000, 0, 0, 0, 32'h40, 32'h20, 32'h0);
    expect_cyc(32'h84, 1, 0, 32'h0, 0);
    idle(1, 0);                                   expect_cyc(32'h80, 0, 0, 32'h0, 0);
    idle(1, 0);                                   expect_cyc(32'h80, 1, 0, 32'h0, 0);
    if (sb.size() != 0) begin
      n_bad++;
      $display("FAIL scoreboard_drain: got %0d entries expected 0", sb.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
